// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
// Definitions shared by the two-lane PHY transmit serializer, the receive
// deserializer and the lane checkers:
//   COMMA              idle / alignment character sent whenever TX has no data
//   BC_THRESH_DEFAULT  consecutive commas needed before a receive lane is active
//   rx_state_t         receive alignment state machine encoding
// -----------------------------------------------------------------------------
package phy_pkg;

    localparam logic [7:0] COMMA             = 8'hBC;
    localparam int         BC_THRESH_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// -----------------------------------------------------------------------------
// rx_shift_reg
// Serial-to-parallel shift register with the byte-boundary bit counter.
// Ports:
//   clk_32f   in   bit clock
//   reset     in   synchronous active-high reset
//   data_in   in   serial bit, MSB of each byte first
//   load      in   comma found by the bit hunt: restart the byte phase
//   count_en  in   advance the bit counter (lane is aligned or aligning)
//   sr        out  last eight received bits, newest in bit 0
//   boundary  out  sr holds one complete aligned byte this cycle
// -----------------------------------------------------------------------------
module rx_shift_reg (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       load,
    input  logic       count_en,
    output logic [7:0] sr,
    output logic       boundary
);

    logic [2:0] bit_cnt;

    // The comma is already complete in sr when load is seen, so the bit
    // being shifted in on this edge is bit 0 of the next byte; starting the
    // counter at 1 makes it wrap to 0 exactly when that byte is complete.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr      <= 8'h00;
            bit_cnt <= 3'd0;
        end else begin
            sr <= {sr[6:0], data_in};
            if (load) begin
                bit_cnt <= 3'd1;
            end else if (count_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign boundary = (bit_cnt == 3'd0);

endmodule

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
// Receive deserializer for one PHY lane. Hunts bit by bit for the idle comma,
// confirms alignment over BC_THRESH consecutive commas, then delivers every
// non-comma byte as a registered word with a one-cycle valid strobe.
// Ports:
//   clk_32f    in   bit clock, all logic on its rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   serial bit, MSB first
//   data_out   out  last accepted non-comma byte
//   valid_out  out  one-cycle strobe, data_out holds a new byte
//   active     out  lane is aligned and delivering bytes
// Parameter:
//   BC_THRESH  consecutive commas to reach ACTIVE, 1..7
// -----------------------------------------------------------------------------
import phy_pkg::*;

module serial_paralelo_rx #(
    parameter int BC_THRESH = BC_THRESH_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [2:0] THRESH = 3'(BC_THRESH);

    rx_state_t  state;
    logic [2:0] bc_cnt;
    logic [2:0] bc_next;
    logic [7:0] sr;
    logic       boundary;
    logic       comma_now;
    logic       load;
    logic       count_en;

    assign comma_now = (sr == COMMA);
    assign load      = (state == SEARCH) && comma_now;
    assign count_en  = (state != SEARCH);
    assign bc_next   = bc_cnt + 3'd1;

    rx_shift_reg u_shift (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .count_en (count_en),
        .sr       (sr),
        .boundary (boundary)
    );

    // Alignment FSM with registered outputs. The comma that ends the bit hunt
    // is already the first one of the run, so bc_cnt starts at 1. Once ACTIVE
    // the lane never drops lock; only reset brings it back to SEARCH.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            bc_cnt    <= 3'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                SEARCH: begin
                    if (comma_now) begin
                        bc_cnt <= 3'd1;
                        if (THRESH == 3'd1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (comma_now) begin
                            bc_cnt <= bc_next;
                            if (bc_next == THRESH) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= 3'd0;
                            state  <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    // Commas are idle fill: data_out keeps the last real byte.
                    if (boundary && !comma_now) begin
                        data_out  <= sr;
                        valid_out <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
